mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit for the execute stage of the pipelined MIPS core, sitting beside the combinational ALU and fed from the same forwarded operand buses. It executes `mult`/`multu`/`div`/`divu` with fixed latencies, holds the HI/LO architectural registers, and services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. A `busy` output lets the hazard unit stall any multiply/divide-class instruction while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `op1`  in  32  rs operand (forwarded); dividend / multiplicand / mthi-mtlo data.
- `op2`  in  32  rt operand (forwarded); divisor / multiplier.
- `md_op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `start`  in  1  E-stage instruction valid for `md_op`; low for bubbles and flushed slots.
- `busy`  out  1  operation in flight.
- `hi`  out  32  HI register (`mfhi` source).
- `lo`  out  32  LO register (`mflo` source).

## Operation
- Idle: counter = 0, `busy` = 0.
- `start` and `md_op` in {1..4} and not busy: latch the full 64-bit result into internal `hi_pend`/`lo_pend`, then load counter with `MULT_CYCLES` or `DIV_CYCLES`. `hi`/`lo` remain unchanged until completion.
- Arithmetic:
  - mult: signed 32×32→64. multu: unsigned. Result is {hi, lo}.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned quotient/remainder.
- Divide by zero (div or divu, op2 = 0): full `DIV_CYCLES` busy; hi/lo unchanged at completion.
- Busy: counter decrements every cycle. On the edge where counter goes 1→0, `hi`/`lo` ← pending values and `busy` falls.
- mthi/mtlo with `start` and not busy: `hi` or `lo` ← op1 at that edge; no busy cycles.
- `start` while busy: ignored (hazard unit guarantees it never occurs; the block must not corrupt state if it does).
- `md_op` = 0 or 7, or `start` = 0: no effect.
- `reset` low at any time, including mid-operation: hi = lo = 0, pending cleared, counter = 0, busy = 0 immediately; the in-flight result is discarded.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0.
- Start sampled at edge E0. `busy` = 1 from after E0 through the cycle before edge E_N (N = MULT_CYCLES / DIV_CYCLES), i.e. exactly N cycles high. New hi/lo are visible in the same cycle `busy` falls.
- Back-to-back: a new `start` is accepted in the first cycle with `busy` = 0.
- mthi/mtlo: value visible one cycle after the start edge.
- `busy` and `hi`/`lo` are registered outputs with no combinational path from inputs.
- Hazard contract (external to this block): stall the D stage when the D instruction is md-class and (`busy` or E-stage `start` with md_op in 1..4).

## Structure
- Shared package/header: `md_op` encodings (`MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`) and default latencies, shared with the controller.
- A single module with behavioural `*`, `/`, `%` for the result latch plus a down-counter; no sub-module. `mult_div_core` may be split out if an iterative divider later replaces the behavioural one.

## Test plan
- mult: op1 = 0xFFFFFFFE (-2), op2 = 3 -> busy exactly 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. Same operands with multu -> hi = 0x00000002, lo = 0xFFFFFFFA.
- div: op1 = -7, op2 = 2 -> busy 10 cycles; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu: 7 / 2 -> lo = 3, hi = 1. div 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- Divide by zero after mthi 0x1234 and mtlo 0x5678 -> busy 10 cycles; hi = 0x1234, lo = 0x5678 unchanged.
- During a mult, `start` with mtlo 0xAAAA in cycle 2 -> ignored; final hi/lo equal the mult result only.
- Assert `reset` low in busy cycle 3 of a div -> busy = 0, hi = lo = 0 immediately; after release, no late write-back.
- Back-to-back: divu accepted the cycle busy falls after a mult -> results correct, with the two busy windows adjacent.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared md_op encodings, default latencies and the result function for the
// multiply/divide unit; also imported by the pipeline controller.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Returns {hi, lo}; divide by zero and non-arithmetic ops return 'keep'.
    // Signed divide goes through magnitudes, so 0x80000000 / -1 needs no special case.
    function automatic logic [63:0] md_compute(input logic [2:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [63:0] keep);
        logic [63:0] res;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        res   = keep;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        quo   = 32'd0;
        rem   = 32'd0;
        case (op)
            MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b != 32'd0) begin
                    quo = mag_a / mag_b;
                    rem = mag_a % mag_b;
                    if (a[31] ^ b[31]) begin
                        quo = 32'd0 - quo;
                    end else begin
                        quo = quo;
                    end
                    if (a[31]) begin
                        rem = 32'd0 - rem;
                    end else begin
                        rem = rem;
                    end
                    res = {rem, quo};
                end else begin
                    res = keep;
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) begin
                    res = {a % b, a / b};
                end else begin
                    res = keep;
                end
            end
            default: res = keep;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit holding the HI/LO registers; results are
// computed on acceptance and released to hi/lo when the down-counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  md_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_pend_r;
    logic [31:0]      lo_pend_r;
    logic [63:0]      result_s;

    // Full 64-bit result for the operation presented this cycle.
    always_comb begin
        result_s = md_compute(md_op, op1, op2, {hi, lo});
    end

    // Accept, count down and retire operations; HI/LO move only at retirement or mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            hi_pend_r <= 32'd0;
            lo_pend_r <= 32'd0;
        end else if (busy) begin
            if (cnt_r == CNT_W'(1)) begin
                hi   <= hi_pend_r;
                lo   <= lo_pend_r;
                busy <= 1'b0;
            end else begin
                busy <= 1'b1;
            end
            cnt_r <= cnt_r - CNT_W'(1);
        end else if (start) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    {hi_pend_r, lo_pend_r} <= result_s;
                    cnt_r                  <= CNT_W'(MULT_CYCLES);
                    busy                   <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    {hi_pend_r, lo_pend_r} <= result_s;
                    cnt_r                  <= CNT_W'(DIV_CYCLES);
                    busy                   <= 1'b1;
                end
                MD_MTHI: hi <= op1;
                MD_MTLO: lo <= op1;
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end else begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO values and
// busy-window lengths.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  md_op;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec_cnt;
    int err_cnt;
    int n;
    int m;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .op1   (op1),
        .op2   (op2),
        .md_op (md_op),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge; returns at the negedge after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_op = op;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    // Count negedges with busy high, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset = 1'b0;
        start = 1'b0;
        md_op = MD_NONE;
        op1   = 32'd0;
        op2   = 32'd0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        reset = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("mult busy", 32'(n), 32'd5);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFFA);

        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("multu hi", hi, 32'h0000_0002);
        check("multu lo", lo, 32'hFFFF_FFFA);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div busy", 32'(n), 32'd10);
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);

        issue(MD_DIVU, 32'd7, 32'd2);
        wait_idle(n);
        check("divu lo", lo, 32'd3);
        check("divu hi", hi, 32'd1);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf lo", lo, 32'h8000_0000);
        check("divovf hi", hi, 32'd0);

        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        check("mthi hi", hi, 32'h0000_1234);
        check("mthi busy", {31'd0, busy}, 32'd0);
        issue(MD_MTLO, 32'h0000_5678, 32'd0);
        check("mtlo lo", lo, 32'h0000_5678);
        check("mtlo hi", hi, 32'h0000_1234);

        // Reserved op and start-low are no-ops.
        issue(MD_RSVD, 32'hDEAD_BEEF, 32'd1);
        check("rsvd busy", {31'd0, busy}, 32'd0);
        check("rsvd lo", lo, 32'h0000_5678);

        issue(MD_DIV, 32'd55, 32'd0);
        wait_idle(n);
        check("div0 busy", 32'(n), 32'd10);
        check("div0 hi", hi, 32'h0000_1234);
        check("div0 lo", lo, 32'h0000_5678);

        // mtlo arriving in busy cycle 2 of a mult must be dropped.
        issue(MD_MULT, 32'h0001_0000, 32'h0003_0000);
        @(negedge clk);
        md_op = MD_MTLO;
        op1   = 32'h0000_AAAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check("ign lo mid", lo, 32'h0000_5678);
        wait_idle(n);
        check("ign busy", 32'(n + 2), 32'd5);
        check("ign hi", hi, 32'd3);
        check("ign lo", lo, 32'd0);

        // Reset in busy cycle 3 of a div.
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("late busy", {31'd0, busy}, 32'd0);
        check("late hi", hi, 32'd0);
        check("late lo", lo, 32'd0);

        // Back-to-back: divu presented in the first idle cycle after a mult.
        issue(MD_MULT, 32'd5, 32'd6);
        wait_idle(n);
        check("b2b mult busy", 32'(n), 32'd5);
        check("b2b mult lo", lo, 32'd30);
        md_op = MD_DIVU;
        op1   = 32'd100;
        op2   = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        wait_idle(m);
        check("b2b divu busy", 32'(m), 32'd10);
        check("b2b divu lo", lo, 32'd14);
        check("b2b divu hi", hi, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
